vga_line_streamer: RTL and testbench

- Downstream consumer of the 8-bit VGA pixel FIFO that sdram_to_vga_fifo fills.
- Generates 1280x1024@60 VGA timing: 108 MHz pixel clock, H total 1688, V total 1066.
- Issues one line-load request per visible line, one line ahead of display.
- Pops one byte per visible pixel and drives registered grey-level pixel, sync and blank outputs.
- Flags FIFO underflow.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/vga_line_streamer_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 79 +++++++
 rtl/vga_line_streamer.sv | 74 +++++++
 tb/tb_vga_line_streamer.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 1280x1024@60 timing constants, counter widths and the timing bundle
// handed from the counter block to display consumers.
package vga_timing_pkg;

  localparam int H_VISIBLE = 1280;
  localparam int H_FP      = 48;
  localparam int H_SYNC    = 112;
  localparam int H_BP      = 248;
  localparam int V_VISIBLE = 1024;
  localparam int V_FP      = 1;
  localparam int V_SYNC    = 3;
  localparam int V_BP      = 38;

  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int H_W    = 11;
  localparam int V_W    = 11;
  localparam int LINE_W = 13;
  localparam int PIX_W  = 8;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} run_state_e;

  typedef struct packed {
    logic           running;
    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           visible;
    logic           hsync_act;
    logic           vsync_act;
    logic           frame_origin;
  } timing_t;

endpackage

// File: rtl/vga_line_streamer_if.sv
// Pixel-side bundle of the line streamer: run control, FIFO read port,
// loader request and the video outputs.
interface vga_line_streamer_if;
  import vga_timing_pkg::*;

  logic              en;
  logic              clr_underflow;
  logic [LINE_W-1:0] line_to_load;
  logic              load_req;
  logic              fifo_aclr;
  logic              fifo_empty;
  logic [PIX_W-1:0]  fifo_data;
  logic              fifo_rdreq;
  logic [PIX_W-1:0]  pixel;
  logic              blank_n;
  logic              hsync;
  logic              vsync;
  logic              frame_start;
  logic              underflow;

  modport master (
    input  en, clr_underflow, fifo_empty, fifo_data,
    output line_to_load, load_req, fifo_aclr, fifo_rdreq,
           pixel, blank_n, hsync, vsync, frame_start, underflow
  );

  modport slave (
    output en, clr_underflow, fifo_empty, fifo_data,
    input  line_to_load, load_req, fifo_aclr, fifo_rdreq,
           pixel, blank_n, hsync, vsync, frame_start, underflow
  );
endinterface

// File: rtl/vga_timing_gen.sv
// h/v raster counters with a run/idle controller; decodes visible and sync
// regions from the live counter values.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP      = vga_timing_pkg::H_FP,
  parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int H_BP      = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP      = vga_timing_pkg::V_FP,
  parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int V_BP      = vga_timing_pkg::V_BP
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    en,
  output timing_t tm
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOT - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOT - 1);
  localparam logic [H_W-1:0] H_VIS_L  = H_W'(H_VISIBLE);
  localparam logic [V_W-1:0] V_VIS_L  = V_W'(V_VISIBLE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_VISIBLE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] VS_START = V_W'(V_VISIBLE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_VISIBLE + V_FP + V_SYNC);

  run_state_e     state, state_nxt;
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;
  logic           running, line_end, frame_wrap;

  assign running    = (state == ST_RUN);
  assign line_end   = (h == H_LAST);
  assign frame_wrap = line_end && (v == V_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // en only matters at the wrap point once running, so frames always finish
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (en) state_nxt = ST_RUN;
      ST_RUN:  if (frame_wrap && !en) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !running) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + V_W'(1);
    end else begin
      h <= h + H_W'(1);
    end
  end

  always_comb begin
    tm              = '0;
    tm.running      = running;
    tm.h            = h;
    tm.v            = v;
    tm.visible      = running && (h < H_VIS_L) && (v < V_VIS_L);
    tm.hsync_act    = running && (h >= HS_START) && (h < HS_END);
    tm.vsync_act    = running && (v >= VS_START) && (v < VS_END);
    tm.frame_origin = running && (h == '0) && (v == '0);
  end

endmodule

// File: rtl/vga_line_streamer.sv
// Streams one FIFO byte per visible pixel onto registered grey-level video,
// prefetching each display line one raster line ahead through the loader.
module vga_line_streamer
  import vga_timing_pkg::*;
#(
  parameter int   H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int   H_FP      = vga_timing_pkg::H_FP,
  parameter int   H_SYNC    = vga_timing_pkg::H_SYNC,
  parameter int   H_BP      = vga_timing_pkg::H_BP,
  parameter int   V_VISIBLE = vga_timing_pkg::V_VISIBLE,
  parameter int   V_FP      = vga_timing_pkg::V_FP,
  parameter int   V_SYNC    = vga_timing_pkg::V_SYNC,
  parameter int   V_BP      = vga_timing_pkg::V_BP,
  parameter logic SYNC_POL  = 1'b1
) (
  input logic               clk,
  input logic               rst_n,
  vga_line_streamer_if.master bus
);

  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOT - 1);
  localparam logic [V_W-1:0] V_REQ_LAST = V_W'(V_VISIBLE - 1);
  localparam logic [H_W-1:0] H_REQ      = H_W'(H_VISIBLE);

  timing_t           tm;
  logic              req_fire;
  logic [LINE_W-1:0] next_line;

  vga_timing_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bus.en),
    .tm    (tm)
  );

  // Fires once the current line's pixels are done; the last blanking line
  // fetches line 0 of the next frame, after vsync has flushed the FIFO.
  assign req_fire  = tm.running && (tm.h == H_REQ) &&
                     ((tm.v == V_LAST) || (tm.v < V_REQ_LAST));
  assign next_line = (tm.v == V_LAST) ? '0 : LINE_W'(tm.v) + LINE_W'(1);

  assign bus.fifo_rdreq = tm.visible & ~bus.fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.pixel        <= '0;
      bus.blank_n      <= 1'b0;
      bus.hsync        <= ~SYNC_POL;
      bus.vsync        <= ~SYNC_POL;
      bus.frame_start  <= 1'b0;
      bus.load_req     <= 1'b0;
      bus.line_to_load <= '0;
      bus.fifo_aclr    <= 1'b0;
      bus.underflow    <= 1'b0;
    end else begin
      bus.pixel       <= (tm.visible && !bus.fifo_empty) ? bus.fifo_data : '0;
      bus.blank_n     <= tm.visible;
      bus.hsync       <= tm.hsync_act ? SYNC_POL : ~SYNC_POL;
      bus.vsync       <= tm.vsync_act ? SYNC_POL : ~SYNC_POL;
      bus.frame_start <= tm.frame_origin;
      bus.load_req    <= req_fire;
      if (req_fire) bus.line_to_load <= next_line;
      bus.fifo_aclr   <= tm.vsync_act;
      // a fresh underflow outranks a simultaneous clear
      if (tm.visible && bus.fifo_empty) bus.underflow <= 1'b1;
      else if (bus.clr_underflow)       bus.underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_line_streamer.sv
// Bench for vga_line_streamer: a reference raster derived from the cycle index,
// a queue-based show-ahead FIFO, and random data and underflow-clear traffic.
module tb_vga_line_streamer;

  // Scaled-down raster so that several whole frames fit in a short run.
  localparam int HV = 40, HFP = 4, HSW = 6, HBP = 10;
  localparam int VV = 12, VFP = 1, VSW = 3, VBP = 4;
  localparam int HT = HV + HFP + HSW + HBP;
  localparam int VT = VV + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam logic POL = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_line_streamer_if bus();

  vga_line_streamer #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP), .SYNC_POL(POL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int cmp = 0, err = 0;
  byte unsigned fifo_q[$];
  bit m_run = 0;
  int n = 0;
  logic [7:0]  e_pix;
  logic [12:0] e_line;
  logic e_blank, e_hs, e_vs, e_fs, e_req, e_aclr, e_uf;
  bit starve = 0;
  int t = 0, last_fs = -1, reqs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  function automatic void feed(input int nb);
    for (int i = 0; i < nb; i++) fifo_q.push_back(8'($urandom));
  endfunction

  function automatic void reset_expect();
    e_pix = '0; e_blank = 1'b0; e_hs = ~POL; e_vs = ~POL; e_fs = 1'b0;
    e_req = 1'b0; e_line = '0; e_aclr = 1'b0; e_uf = 1'b0;
  endfunction

  // One pixel clock: drive inputs, check last cycle's registered outputs and
  // this cycle's read strobe, then predict what the next edge must register.
  task automatic cycle(input bit rst_v, input bit en_v);
    int h, v, line, nb;
    bit vis, empty, clr, pop, req_now, aclr_now;
    rst_n = rst_v;
    bus.en = en_v;
    clr = ($urandom_range(0, 5) == 0);
    bus.clr_underflow = clr;
    empty = (fifo_q.size() == 0);
    bus.fifo_empty = empty;
    bus.fifo_data = empty ? 8'($urandom) : fifo_q[0];
    @(negedge clk);
    t++;
    chk("pixel", bus.pixel, e_pix);
    chk("blank_n", bus.blank_n, e_blank);
    chk("hsync", bus.hsync, e_hs);
    chk("vsync", bus.vsync, e_vs);
    chk("frame_start", bus.frame_start, e_fs);
    chk("load_req", bus.load_req, e_req);
    chk("line_to_load", bus.line_to_load, e_line);
    chk("fifo_aclr", bus.fifo_aclr, e_aclr);
    chk("underflow", bus.underflow, e_uf);
    if (bus.load_req === 1'b1) reqs++;
    if (bus.frame_start === 1'b1) begin
      if (last_fs >= 0) begin
        chk("frame_period", t - last_fs, FT);
        chk("reqs_per_frame", reqs, VV);
      end
      last_fs = t;
      reqs = 0;
    end
    h = n % HT;
    v = (n / HT) % VT;
    vis = m_run && h < HV && v < VV;
    pop = vis && !empty;
    chk("fifo_rdreq", bus.fifo_rdreq, pop);
    req_now = 1'b0;
    aclr_now = 1'b0;
    if (!rst_v) reset_expect();
    else begin
      e_pix   = pop ? fifo_q[0] : 8'h00;
      e_blank = vis;
      e_hs    = (m_run && h >= HV + HFP && h < HV + HFP + HSW) ? POL : ~POL;
      e_vs    = (m_run && v >= VV + VFP && v < VV + VFP + VSW) ? POL : ~POL;
      e_fs    = m_run && h == 0 && v == 0;
      req_now = m_run && h == HV && (v == VT - 1 || v < VV - 1);
      e_req   = req_now;
      if (req_now) e_line = (v == VT - 1) ? 13'd0 : 13'(v + 1);
      aclr_now = m_run && v >= VV + VFP && v < VV + VFP + VSW;
      e_aclr  = aclr_now;
      e_uf    = (vis && empty) ? 1'b1 : (clr ? 1'b0 : e_uf);
    end
    @(posedge clk);
    #1;
    if (pop) void'(fifo_q.pop_front());
    if (!rst_v) begin
      m_run = 0; n = 0; fifo_q.delete(); last_fs = -1;
    end else begin
      if (aclr_now) fifo_q.delete();
      if (req_now) begin
        line = (v == VT - 1) ? 0 : v + 1;
        nb = HV;
        if (starve && line == 10) nb = 20;
        if (starve && line == 11) nb = 0;
        feed(nb);
      end
      if (m_run) begin
        if ((n % FT) == FT - 1 && !en_v) begin
          m_run = 0; n = 0; last_fs = -1;
        end else n++;
      end else if (en_v) begin
        m_run = 1; n = 0;
      end
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.clr_underflow = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_data = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_expect();
    repeat (3) cycle(1'b0, 1'b0);
    feed(HV);
    repeat (5) cycle(1'b1, 1'b0);
    repeat (2 * FT + 10) cycle(1'b1, 1'b1);
    // short-fed lines 10 and 11 exercise underflow and set-beats-clear
    starve = 1;
    repeat (FT) cycle(1'b1, 1'b1);
    starve = 0;
    repeat ($urandom_range(100, FT - 100)) cycle(1'b1, 1'b1);
    repeat (FT + 200) cycle(1'b1, 1'b0);
    // restart, then abandon the frame near h=20, v=6 with a reset
    repeat (6 * HT + 21) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    feed(HV);
    repeat (3) cycle(1'b1, 1'b0);
    repeat (FT + 50) cycle(1'b1, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
